// File: rtl/qmac_requant_if.sv
// Control, product-stream and result bundle between the multiplier side and qmac_requant.
interface qmac_requant_if #(
   parameter int N     = 8,
   parameter int ACC_W = 40,
   parameter int LEN_W = 10
);
   logic                    start;
   logic signed [31:0]      bias_din;
   logic [LEN_W-1:0]        len_din;
   logic                    relu_en;
   logic signed [31:0]      product_din;
   logic                    product_din_vld;
   logic                    busy;
   logic [ACC_W-1:0]        acc_dout;
   logic [N-1:0]            q_dout;
   logic                    dout_vld;

   modport master (
      output start, bias_din, len_din, relu_en, product_din, product_din_vld,
      input  busy, acc_dout, q_dout, dout_vld
   );

   modport slave (
      input  start, bias_din, len_din, relu_en, product_din, product_din_vld,
      output busy, acc_dout, q_dout, dout_vld
   );
endinterface

// File: rtl/qmac_requant.sv
// Accumulates len products onto a bias, then rounds, shifts, ReLUs and saturates to N bits.
// dout_vld 2 cycles after the last product (or after start when len=0); no backpressure, start ignored while busy.
module qmac_requant #(
   parameter int N     = 8,
   parameter int ACC_W = 40,
   parameter int SHIFT = 4,
   parameter int LEN_W = 10
) (
   input  logic          clk,
   input  logic          rst_n,
   qmac_requant_if.slave bus
);
   typedef enum logic [1:0] {IDLE, ACC, POST, OUT} state_t;

   localparam logic [ACC_W-1:0] RND = ACC_W'((64'd1 << SHIFT) >> 1);
   localparam logic signed [ACC_W-1:0] QMAX = {{(ACC_W-N+1){1'b0}}, {(N-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] QMIN = {{(ACC_W-N+1){1'b1}}, {(N-1){1'b0}}};

   state_t                  state_q, state_d;
   logic [ACC_W-1:0]        acc_q;
   logic [LEN_W-1:0]        count_q;
   logic [LEN_W-1:0]        len_q;
   logic                    relu_q;
   logic [LEN_W-1:0]        count_inc;
   logic [ACC_W-1:0]        sum;
   logic signed [ACC_W-1:0] r;
   logic [N-1:0]            q_next;
   logic [ACC_W-1:0]        bias_ext;
   logic [ACC_W-1:0]        prod_ext;

   assign bias_ext  = {{(ACC_W-32){bus.bias_din[31]}}, bus.bias_din};
   assign prod_ext  = {{(ACC_W-32){bus.product_din[31]}}, bus.product_din};
   assign count_inc = count_q + 1'b1;
   assign bus.busy  = (state_q == ACC) || (state_q == POST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (bus.start) state_d = (bus.len_din != '0) ? ACC : POST;
         ACC:  if (bus.product_din_vld && (count_inc == len_q)) state_d = POST;
         POST: state_d = OUT;
         OUT:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Rounding add wraps at ACC_W bits; the arithmetic shift makes ties round toward +inf.
   always_comb begin
      sum    = acc_q + RND;
      r      = $signed(sum) >>> SHIFT;
      q_next = r[N-1:0];
      if (relu_q && r[ACC_W-1]) q_next = '0;
      else if (r > QMAX)        q_next = QMAX[N-1:0];
      else if (r < QMIN)        q_next = QMIN[N-1:0];
   end

   // Result registers load at the POST->OUT edge so they are valid alongside dout_vld.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q        <= '0;
         count_q      <= '0;
         len_q        <= '0;
         relu_q       <= 1'b0;
         bus.acc_dout <= '0;
         bus.q_dout   <= '0;
         bus.dout_vld <= 1'b0;
      end else begin
         bus.dout_vld <= 1'b0;
         case (state_q)
            IDLE: if (bus.start) begin
               acc_q   <= bias_ext;
               count_q <= '0;
               len_q   <= bus.len_din;
               relu_q  <= bus.relu_en;
            end
            ACC: if (bus.product_din_vld) begin
               acc_q   <= acc_q + prod_ext;
               count_q <= count_inc;
            end
            POST: begin
               bus.acc_dout <= acc_q;
               bus.q_dout   <= q_next;
               bus.dout_vld <= 1'b1;
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_qmac_requant.sv
// Randomized and directed bench for qmac_requant against an arithmetic reference model.
module tb_qmac_requant;
   localparam int N     = 8;
   localparam int ACC_W = 40;
   localparam int SHIFT = 4;
   localparam int LEN_W = 10;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   int   checks = 0;
   int   errors = 0;

   qmac_requant_if #(.N(N), .ACC_W(ACC_W), .LEN_W(LEN_W)) bus ();

   qmac_requant #(.N(N), .ACC_W(ACC_W), .SHIFT(SHIFT), .LEN_W(LEN_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1);
   end

   function automatic longint floor_div(input longint n, input longint d);
      longint q;
      q = n / d;
      if ((n % d != 0) && (n < 0)) q = q - 1;
      return q;
   endfunction

   // Reference: plain integer sum, round-half-up division by 2^SHIFT, ReLU, clamp.
   function automatic void model(input int bias, input int prods[$], input bit relu,
                                 output logic [ACC_W-1:0] acc_e, output logic [N-1:0] q_e);
      longint s, r, hi, lo, d;
      s = longint'(bias);
      foreach (prods[i]) s += longint'(prods[i]);
      acc_e = s[ACC_W-1:0];
      d  = longint'(1) << SHIFT;
      r  = floor_div(s + d / 2, d);
      hi = (longint'(1) << (N-1)) - 1;
      lo = -hi - 1;
      if (relu && r < 0) r = 0;
      else if (r > hi)   r = hi;
      else if (r < lo)   r = lo;
      q_e = r[N-1:0];
   endfunction

   // Drives one run; lat counts cycles from the last product (or start) to dout_vld, -1 if early, 99 if never.
   task automatic do_run(input int bias, input int prods[$], input bit relu, input int gap, input bit poke,
                         output logic [ACC_W-1:0] acc_o, output logic [N-1:0] q_o,
                         output int lat, output int busy_n);
      bit early;
      early  = 1'b0;
      busy_n = 0;
      lat    = 99;
      acc_o  = '0;
      q_o    = '0;
      @(negedge clk);
      bus.start    = 1'b1;
      bus.bias_din = bias;
      bus.len_din  = LEN_W'(prods.size());
      bus.relu_en  = relu;
      foreach (prods[i]) begin
         for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            busy_n += int'(bus.busy);
            if (bus.dout_vld) early = 1'b1;
            bus.start           = poke && (i == 1) && (g == 0);
            bus.product_din_vld = (g == gap - 1);
            bus.product_din     = prods[i];
         end
      end
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         bus.start           = 1'b0;
         bus.product_din_vld = 1'b0;
         busy_n += int'(bus.busy);
         if (bus.dout_vld) begin
            lat   = early ? -1 : k;
            acc_o = bus.acc_dout;
            q_o   = bus.q_dout;
            break;
         end
      end
   endtask

   task automatic test_reset();
      bus.start = 0; bus.bias_din = 0; bus.len_din = 0; bus.relu_en = 0;
      bus.product_din = 0; bus.product_din_vld = 0;
      #2 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
      checks++; if (bus.dout_vld !== 1'b0) begin errors++; $display("FAIL reset_dout_vld: got %b expected 0", bus.dout_vld); end
      checks++; if (bus.acc_dout !== '0) begin errors++; $display("FAIL reset_acc_dout: got %h expected 0", bus.acc_dout); end
      checks++; if (bus.q_dout !== '0) begin errors++; $display("FAIL reset_q_dout: got %h expected 0", bus.q_dout); end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_basic();
      logic [ACC_W-1:0] acc_o; logic [N-1:0] q_o; int lat, busy_n;
      int p[$] = '{16, 32, 48};
      do_run(0, p, 1'b0, 9, 1'b0, acc_o, q_o, lat, busy_n);
      checks++; if (acc_o !== 40'd96) begin errors++; $display("FAIL basic_acc: got %0d expected 96", $signed(acc_o)); end
      checks++; if (q_o !== 8'd6) begin errors++; $display("FAIL basic_q: got %0d expected 6", $signed(q_o)); end
      checks++; if (lat !== 2) begin errors++; $display("FAIL basic_latency: got %0d expected 2", lat); end
      checks++; if (busy_n !== 28) begin errors++; $display("FAIL basic_busy: got %0d expected 28", busy_n); end
   endtask

   task automatic test_relu();
      logic [ACC_W-1:0] acc_o; logic [N-1:0] q_o; int lat, busy_n;
      int p[$] = '{-100, -60};
      do_run(0, p, 1'b0, 2, 1'b0, acc_o, q_o, lat, busy_n);
      checks++; if ($signed(acc_o) !== -40'sd160) begin errors++; $display("FAIL neg_acc: got %0d expected -160", $signed(acc_o)); end
      checks++; if (q_o !== 8'hF6) begin errors++; $display("FAIL neg_q: got %h expected f6", q_o); end
      do_run(0, p, 1'b1, 1, 1'b0, acc_o, q_o, lat, busy_n);
      checks++; if ($signed(acc_o) !== -40'sd160) begin errors++; $display("FAIL relu_acc: got %0d expected -160", $signed(acc_o)); end
      checks++; if (q_o !== 8'h00) begin errors++; $display("FAIL relu_q: got %h expected 00", q_o); end
      checks++; if (lat !== 2) begin errors++; $display("FAIL relu_latency: got %0d expected 2", lat); end
   endtask

   task automatic test_saturation();
      logic [ACC_W-1:0] acc_o; logic [N-1:0] q_o; int lat, busy_n;
      int p[$];
      p = '{10000};
      do_run(0, p, 1'b0, 3, 1'b0, acc_o, q_o, lat, busy_n);
      checks++; if (q_o !== 8'h7F) begin errors++; $display("FAIL sat_pos_q: got %h expected 7f", q_o); end
      checks++; if (acc_o !== 40'd10000) begin errors++; $display("FAIL sat_pos_acc: got %0d expected 10000", $signed(acc_o)); end
      p = '{-10000};
      do_run(0, p, 1'b0, 1, 1'b0, acc_o, q_o, lat, busy_n);
      checks++; if (q_o !== 8'h80) begin errors++; $display("FAIL sat_neg_q: got %h expected 80", q_o); end
      checks++; if ($signed(acc_o) !== -40'sd10000) begin errors++; $display("FAIL sat_neg_acc: got %0d expected -10000", $signed(acc_o)); end
   endtask

   task automatic test_len_zero();
      logic [ACC_W-1:0] acc_o; logic [N-1:0] q_o; int lat, busy_n;
      int p[$];
      p = {};
      do_run(40, p, 1'b0, 1, 1'b0, acc_o, q_o, lat, busy_n);
      checks++; if (q_o !== 8'd3) begin errors++; $display("FAIL len0_q: got %0d expected 3", $signed(q_o)); end
      checks++; if (acc_o !== 40'd40) begin errors++; $display("FAIL len0_acc: got %0d expected 40", $signed(acc_o)); end
      checks++; if (lat !== 2) begin errors++; $display("FAIL len0_latency: got %0d expected 2", lat); end
      checks++; if (busy_n !== 1) begin errors++; $display("FAIL len0_busy: got %0d expected 1", busy_n); end
   endtask

   task automatic test_idle_vld();
      logic [ACC_W-1:0] acc_o, acc_e; logic [N-1:0] q_o, q_e; int lat, busy_n;
      int p[$] = '{32};
      bit bad = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (bus.busy !== 1'b0 || bus.dout_vld !== 1'b0) bad = 1'b1;
         bus.product_din_vld = 1'b1;
         bus.product_din     = 1000 * (i + 1);
      end
      @(negedge clk);
      bus.product_din_vld = 1'b0;
      if (bus.busy !== 1'b0 || bus.dout_vld !== 1'b0) bad = 1'b1;
      checks++; if (bad !== 1'b0) begin errors++; $display("FAIL idle_vld_quiet: got %b expected 0", bad); end
      model(0, p, 1'b0, acc_e, q_e);
      do_run(0, p, 1'b0, 1, 1'b0, acc_o, q_o, lat, busy_n);
      checks++; if (acc_o !== acc_e) begin errors++; $display("FAIL idle_vld_acc: got %0d expected %0d", $signed(acc_o), $signed(acc_e)); end
      checks++; if (q_o !== q_e) begin errors++; $display("FAIL idle_vld_q: got %0d expected %0d", $signed(q_o), $signed(q_e)); end
   endtask

   task automatic test_start_mid_acc();
      logic [ACC_W-1:0] acc_o, acc_e; logic [N-1:0] q_o, q_e; int lat, busy_n;
      int p[$] = '{300, -50, 700};
      model(-20, p, 1'b0, acc_e, q_e);
      do_run(-20, p, 1'b0, 3, 1'b1, acc_o, q_o, lat, busy_n);
      checks++; if (acc_o !== acc_e) begin errors++; $display("FAIL midstart_acc: got %0d expected %0d", $signed(acc_o), $signed(acc_e)); end
      checks++; if (q_o !== q_e) begin errors++; $display("FAIL midstart_q: got %0d expected %0d", $signed(q_o), $signed(q_e)); end
      checks++; if (lat !== 2) begin errors++; $display("FAIL midstart_latency: got %0d expected 2", lat); end
      checks++; if (busy_n !== 10) begin errors++; $display("FAIL midstart_busy: got %0d expected 10", busy_n); end
   endtask

   task automatic test_back_to_back();
      logic [ACC_W-1:0] acc_o, acc_e; logic [N-1:0] q_o, q_e; int lat, busy_n;
      int pa[$] = '{500};
      int pc[$] = '{-77, 33};
      int seen = 0;
      do_run(0, pa, 1'b0, 1, 1'b0, acc_o, q_o, lat, busy_n);
      // Still in the dout_vld cycle: this start must be dropped.
      bus.start = 1'b1; bus.bias_din = 999; bus.len_din = '0; bus.relu_en = 1'b0;
      @(negedge clk);
      bus.start = 1'b0;
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL b2b_start_in_out_busy: got %b expected 0", bus.busy); end
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         seen += int'(bus.dout_vld);
      end
      checks++; if (seen !== 0) begin errors++; $display("FAIL b2b_start_in_out_vld: got %0d pulses expected 0", seen); end
      do_run(0, pa, 1'b0, 2, 1'b0, acc_o, q_o, lat, busy_n);
      model(64, pc, 1'b0, acc_e, q_e);
      do_run(64, pc, 1'b0, 1, 1'b0, acc_o, q_o, lat, busy_n);
      checks++; if (acc_o !== acc_e) begin errors++; $display("FAIL b2b_acc: got %0d expected %0d", $signed(acc_o), $signed(acc_e)); end
      checks++; if (q_o !== q_e) begin errors++; $display("FAIL b2b_q: got %0d expected %0d", $signed(q_o), $signed(q_e)); end
      checks++; if (lat !== 2) begin errors++; $display("FAIL b2b_latency: got %0d expected 2", lat); end
   endtask

   task automatic test_random();
      logic [ACC_W-1:0] acc_o, acc_e; logic [N-1:0] q_o, q_e; int lat, busy_n;
      int p[$]; int bias, len, gap; bit relu;
      for (int r = 0; r < 16; r++) begin
         p    = {};
         len  = int'($urandom_range(0, 5));
         gap  = int'($urandom_range(1, 3));
         relu = 1'($urandom_range(0, 1));
         bias = int'($urandom_range(0, 2097152)) - 1048576;
         for (int i = 0; i < len; i++) begin
            if (r % 2 == 0) p.push_back(int'($urandom_range(0, 4096)) - 2048);
            else            p.push_back(int'($urandom_range(0, 33554432)) - 16777216);
         end
         model(bias % ((r % 2 == 0) ? 1024 : 1048576), p, relu, acc_e, q_e);
         do_run(bias % ((r % 2 == 0) ? 1024 : 1048576), p, relu, gap, 1'b0, acc_o, q_o, lat, busy_n);
         checks++; if (acc_o !== acc_e) begin errors++; $display("FAIL rand%0d_acc: got %0d expected %0d", r, $signed(acc_o), $signed(acc_e)); end
         checks++; if (q_o !== q_e) begin errors++; $display("FAIL rand%0d_q: got %0d expected %0d", r, $signed(q_o), $signed(q_e)); end
         checks++; if (lat !== 2) begin errors++; $display("FAIL rand%0d_latency: got %0d expected 2", r, lat); end
         checks++; if (busy_n !== gap * len + 1) begin errors++; $display("FAIL rand%0d_busy: got %0d expected %0d", r, busy_n, gap * len + 1); end
      end
   endtask

   task automatic test_reset_mid_run();
      logic [ACC_W-1:0] acc_o, acc_e; logic [N-1:0] q_o, q_e; int lat, busy_n;
      int p[$] = '{100, 200, 300};
      int seen = 0;
      @(negedge clk);
      bus.start = 1'b1; bus.bias_din = 5; bus.len_din = 10'd3; bus.relu_en = 1'b0;
      @(negedge clk);
      bus.start = 1'b0; bus.product_din_vld = 1'b1; bus.product_din = 100;
      @(negedge clk);
      bus.product_din_vld = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL midreset_busy: got %b expected 0", bus.busy); end
      checks++; if (bus.acc_dout !== '0) begin errors++; $display("FAIL midreset_acc_dout: got %h expected 0", bus.acc_dout); end
      checks++; if (bus.q_dout !== '0) begin errors++; $display("FAIL midreset_q_dout: got %h expected 0", bus.q_dout); end
      checks++; if (bus.dout_vld !== 1'b0) begin errors++; $display("FAIL midreset_dout_vld: got %b expected 0", bus.dout_vld); end
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         seen += int'(bus.dout_vld);
         bus.product_din_vld = (i == 1) || (i == 3);
         bus.product_din     = 200;
      end
      bus.product_din_vld = 1'b0;
      checks++; if (seen !== 0) begin errors++; $display("FAIL midreset_no_result: got %0d pulses expected 0", seen); end
      model(5, p, 1'b0, acc_e, q_e);
      do_run(5, p, 1'b0, 2, 1'b0, acc_o, q_o, lat, busy_n);
      checks++; if (acc_o !== acc_e) begin errors++; $display("FAIL postreset_acc: got %0d expected %0d", $signed(acc_o), $signed(acc_e)); end
      checks++; if (q_o !== q_e) begin errors++; $display("FAIL postreset_q: got %0d expected %0d", $signed(q_o), $signed(q_e)); end
      checks++; if (lat !== 2) begin errors++; $display("FAIL postreset_latency: got %0d expected 2", lat); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_relu();
      test_saturation();
      test_len_zero();
      test_idle_vld();
      test_start_mid_acc();
      test_back_to_back();
      test_random();
      test_reset_mid_run();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
